// File: rtl/givens_pkg.sv
// Shared types and constants for the Givens QR scheduler: FSM states, FP32 field
// positions for the zero-element test, and the default rotation-unit latency.
package givens_pkg;

  localparam int FP_W       = 32;
  localparam int FP_SIGN    = 31;
  localparam int FP_EXP_MSB = 30;
  localparam int FP_EXP_LSB = 23;
  localparam int FP_MAN_MSB = 22;
  localparam int FP_MAN_LSB = 0;

  // Also used where the rotation unit itself is instantiated, so both agree.
  localparam int GR_LAT_DEF = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CS,
    S_APPLY,
    S_NEXT,
    S_FIN
  } state_t;

  // True for +0 and -0: sign is ignored, exponent and mantissa must be clear.
  function automatic logic fp_is_zero(input logic [FP_W-1:0] v);
    logic [FP_W-1:0] m;
    m = v;
    m[FP_SIGN] = 1'b0;
    return ({m[FP_EXP_MSB:FP_EXP_LSB], m[FP_MAN_MSB:FP_MAN_LSB]} == '0);
  endfunction

endpackage

// File: rtl/givens_lat_cnt.sv
// Loadable down-counter that parks at zero; tc flags the enabled cycle in which
// the count has reached zero.
module givens_lat_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (!reset)                    count <= '0;
    else if (load)                 count <= load_val;
    else if (en && count != '0)    count <= count - CNT_W'(1);
  end

  assign tc = en && (count == '0);

endmodule

// File: rtl/givens_qr_sched.sv
// Column-by-column, bottom-up Givens QR scheduler: one rotation in flight, then one
// row-update command per remaining column. Define GIVENS_SKIP_ZERO_EN to skip zero b.
module givens_qr_sched
  import givens_pkg::*;
#(
  parameter int N      = 4,
  parameter int GR_LAT = GR_LAT_DEF,
  parameter int IDX_W  = $clog2(N),
  parameter int CNT_W  = $clog2(GR_LAT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      b_elem,
  input  logic             upd_ready,
  output logic             busy,
  output logic             done,
  output logic             gr_start,
  output logic [IDX_W-1:0] row_top,
  output logic [IDX_W-1:0] row_bot,
  output logic [IDX_W-1:0] col,
  output logic             cs_latch,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_col,
  output logic [7:0]       rot_cnt
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] row_bot_q, col_q, upd_col_q;
  logic [7:0]       rot_cnt_q;
  logic             cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_val;
  logic             more_rows, more_cols;

  givens_lat_cnt #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(GR_LAT - 1)),
    .en       (cnt_en),
    .count    (cnt_val),
    .tc       (cnt_tc)
  );

  // Extra bit so col+1 cannot wrap when col is at the top of its range.
  assign more_rows = (IDX_W+1)'(row_bot_q) > ((IDX_W+1)'(col_q) + (IDX_W+1)'(1));
  assign more_cols = int'(col_q) < (N - 2);

`ifndef GIVENS_SKIP_ZERO_EN
  logic unused_b_elem;
  assign unused_b_elem = ^{b_elem, cnt_val};
`else
  logic unused_cnt_val;
  assign unused_cnt_val = ^cnt_val;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    gr_start  = 1'b0;
    cs_latch  = 1'b0;
    upd_valid = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
`ifdef GIVENS_SKIP_ZERO_EN
        if (fp_is_zero(b_elem)) begin
          state_d = S_NEXT;
        end else begin
          gr_start = 1'b1;
          cnt_load = 1'b1;
          state_d  = S_WAIT_CS;
        end
`else
        gr_start = 1'b1;
        cnt_load = 1'b1;
        state_d  = S_WAIT_CS;
`endif
      end
      S_WAIT_CS: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          cs_latch = 1'b1;
          state_d  = S_APPLY;
        end
      end
      S_APPLY: begin
        upd_valid = 1'b1;
        if (upd_ready && upd_col_q == LAST) state_d = S_NEXT;
      end
      S_NEXT:  state_d = (more_rows || more_cols) ? S_ISSUE : S_FIN;
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_bot_q <= '0;
      col_q     <= '0;
      upd_col_q <= '0;
      rot_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          col_q     <= '0;
          row_bot_q <= LAST;
          rot_cnt_q <= '0;
        end
        S_ISSUE: upd_col_q <= col_q;
        S_APPLY: if (upd_ready && upd_col_q != LAST) upd_col_q <= upd_col_q + IDX_W'(1);
        S_NEXT: begin
          rot_cnt_q <= rot_cnt_q + 8'd1;
          if (more_rows) begin
            row_bot_q <= row_bot_q - IDX_W'(1);
          end else if (more_cols) begin
            col_q     <= col_q + IDX_W'(1);
            row_bot_q <= LAST;
          end
        end
        default: ;
      endcase
    end
  end

  // row_bot is never 0 while a pair is active; the guard keeps row_top 0 when idle.
  assign row_top = (row_bot_q == '0) ? '0 : row_bot_q - IDX_W'(1);
  assign row_bot = row_bot_q;
  assign col     = col_q;
  assign upd_col = upd_col_q;
  assign rot_cnt = rot_cnt_q;

endmodule

// File: tb/tb_givens_qr_sched.sv
// Self-checking bench for givens_qr_sched: N=4/GR_LAT=40 main instance and an
// N=2/GR_LAT=5 instance stepped cycle by cycle.
module tb_givens_qr_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] b_elem;

  logic       start_a, upd_ready_a;
  logic       busy_a, done_a, gr_start_a, cs_latch_a, upd_valid_a;
  logic [1:0] row_top_a, row_bot_a, col_a, upd_col_a;
  logic [7:0] rot_cnt_a;

  logic       start_b, upd_ready_b;
  logic       busy_b, done_b, gr_start_b, cs_latch_b, upd_valid_b;
  logic [0:0] row_top_b, row_bot_b, col_b, upd_col_b;
  logic [7:0] rot_cnt_b;

  always #5 clk = ~clk;

  givens_qr_sched #(.N(4), .GR_LAT(40)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .b_elem(b_elem), .upd_ready(upd_ready_a),
    .busy(busy_a), .done(done_a), .gr_start(gr_start_a), .row_top(row_top_a),
    .row_bot(row_bot_a), .col(col_a), .cs_latch(cs_latch_a), .upd_valid(upd_valid_a),
    .upd_col(upd_col_a), .rot_cnt(rot_cnt_a));

  givens_qr_sched #(.N(2), .GR_LAT(5)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .b_elem(b_elem), .upd_ready(upd_ready_b),
    .busy(busy_b), .done(done_b), .gr_start(gr_start_b), .row_top(row_top_b),
    .row_bot(row_bot_b), .col(col_b), .cs_latch(cs_latch_b), .upd_valid(upd_valid_b),
    .upd_col(upd_col_b), .rot_cnt(rot_cnt_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Event log of dut_a, appended only; each test remembers where its slice begins.
  int          cyc = 0;
  logic [11:0] gs_q[$];
  int          gs_cyc[$];
  int          cs_cyc[$];
  int          hs_q[$];
  int          done_cnt = 0, done_cyc = 0, hold_viol = 0;
  logic        prev_stall = 1'b0;
  logic [1:0]  prev_col = '0;
  int          gs0, cs0, hs0, d0, hv0;

  logic [11:0] exp_gs[$];
  int          exp_hs[$];

  typedef struct {int top; int bot; int col; int first; int ncmd;} rot_vec_t;
  typedef struct {logic gs; logic cs; logic uv; int ucol; logic dn; logic bsy;} cyc_vec_t;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (gr_start_a) begin
        gs_q.push_back({4'(row_top_a), 4'(row_bot_a), 4'(col_a)});
        gs_cyc.push_back(cyc);
      end
      if (cs_latch_a) cs_cyc.push_back(cyc);
      if (upd_valid_a && upd_ready_a) hs_q.push_back(int'(upd_col_a));
      if (done_a) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (prev_stall && (!upd_valid_a || upd_col_a != prev_col)) hold_viol <= hold_viol + 1;
      prev_stall <= upd_valid_a && !upd_ready_a;
      prev_col   <= upd_col_a;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: every sub-diagonal element, column-major, bottom-up; updates col..n-1.
  function automatic void build_model(input int n, input bit skip_first);
    bit first = 1'b1;
    exp_gs.delete();
    exp_hs.delete();
    for (int c = 0; c < n - 1; c++)
      for (int b = n - 1; b > c; b--) begin
        if (!(skip_first && first)) begin
          exp_gs.push_back({4'(b - 1), 4'(b), 4'(c)});
          for (int u = c; u < n; u++) exp_hs.push_back(u);
        end
        first = 1'b0;
      end
  endfunction

  task automatic mark();
    gs0 = gs_q.size(); cs0 = cs_cyc.size(); hs0 = hs_q.size();
    d0 = done_cnt; hv0 = hold_viol;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic kick_a();
    start_a = 1'b1; step(); start_a = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int i = 0;
    while (busy_a && i < maxc) begin step(); i++; end
    check({tag, " run finished"}, busy_a, 1'b0);
  endtask

  task automatic wait_apply(input string tag);
    int i = 0;
    while (!upd_valid_a && i < 200) begin step(); i++; end
    check({tag, " reached APPLY"}, upd_valid_a, 1'b1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " ctl outputs"}, {busy_a, done_a, gr_start_a, cs_latch_a, upd_valid_a}, 5'b0);
    check({tag, " index outputs"}, {row_top_a, row_bot_a, col_a, upd_col_a}, 8'h0);
    check({tag, " rot_cnt"}, rot_cnt_a, 8'd0);
  endtask

  task automatic compare_run(input string tag, input int lat, input int exp_rot);
    int ng, nc, nh, e;
    ng = gs_q.size() - gs0; nc = cs_cyc.size() - cs0; nh = hs_q.size() - hs0;
    check({tag, " gr_start count"}, ng, exp_gs.size());
    check({tag, " cs_latch count"}, nc, exp_gs.size());
    check({tag, " handshake count"}, nh, exp_hs.size());
    for (int i = 0; i < ng && i < exp_gs.size(); i++)
      check($sformatf("%s pair%0d {top,bot,col}", tag, i), gs_q[gs0 + i], exp_gs[i]);
    e = 0;
    for (int i = 0; i < nh && i < exp_hs.size(); i++) if (hs_q[hs0 + i] != exp_hs[i]) e++;
    check({tag, " upd_col order errors"}, e, 0);
    e = 0;
    for (int i = 0; i < ng && i < nc; i++) if (cs_cyc[cs0 + i] - gs_cyc[gs0 + i] != lat) e++;
    check({tag, " cs_latch latency errors"}, e, 0);
    check({tag, " done pulses"}, done_cnt - d0, 1);
    check({tag, " stalled command changed"}, hold_viol - hv0, 0);
    check({tag, " rot_cnt"}, rot_cnt_a, exp_rot);
  endtask

  initial begin
    rot_vec_t tbl[6];
    cyc_vec_t bt[11];
    int e, dsnap, gsnap;
    bit skip_on;
`ifdef GIVENS_SKIP_ZERO_EN
    skip_on = 1'b1;
`else
    skip_on = 1'b0;
`endif
    tbl[0] = '{2, 3, 0, 0, 4}; tbl[1] = '{1, 2, 0, 0, 4}; tbl[2] = '{0, 1, 0, 0, 4};
    tbl[3] = '{2, 3, 1, 1, 3}; tbl[4] = '{1, 2, 1, 1, 3}; tbl[5] = '{2, 3, 2, 2, 2};
    // N=2, GR_LAT=5 from the ISSUE cycle onward; ucol -1 means not checked.
    bt[0]  = '{1, 0, 0, -1, 0, 1};
    for (int i = 1; i < 5; i++) bt[i] = '{0, 0, 0, -1, 0, 1};
    bt[5]  = '{0, 1, 0, -1, 0, 1};
    bt[6]  = '{0, 0, 1, 0, 0, 1};
    bt[7]  = '{0, 0, 1, 1, 0, 1};
    bt[8]  = '{0, 0, 0, -1, 0, 1};
    bt[9]  = '{0, 0, 0, -1, 1, 1};
    bt[10] = '{0, 0, 0, -1, 0, 0};

    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    upd_ready_a = 1'b1; upd_ready_b = 1'b1; b_elem = 32'h3f80_0000;
    repeat (3) step();
    check_idle_zero("reset");
    reset = 1'b1;
    step();

    // Basic run against the listed pair/update table and the total cycle count.
    mark(); kick_a(); wait_idle("basic", 2000);
    build_model(4, 1'b0);
    compare_run("basic", 40, 6);
    e = 0;
    for (int r = 0, k = hs0; r < 6; r++) begin
      if (gs0 + r < gs_q.size())
        check($sformatf("table row%0d pair", r), gs_q[gs0 + r],
              {4'(tbl[r].top), 4'(tbl[r].bot), 4'(tbl[r].col)});
      for (int j = 0; j < tbl[r].ncmd; j++, k++)
        if (k >= hs_q.size() || hs_q[k] != tbl[r].first + j) e++;
    end
    check("table upd_col errors", e, 0);
    if (gs0 < gs_cyc.size()) check("basic done cycle", done_cyc - gs_cyc[gs0], 272);

    // Backpressure: five stalled cycles at the start of the first APPLY.
    upd_ready_a = 1'b0;
    mark(); kick_a(); wait_apply("bp");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp stall%0d valid/col", i), {upd_valid_a, upd_col_a}, 3'b100);
      step();
    end
    upd_ready_a = 1'b1;
    wait_idle("bp", 2000);
    compare_run("bp", 40, 6);
    if (gs0 < gs_cyc.size()) check("bp done cycle", done_cyc - gs_cyc[gs0], 277);

    // start while busy must be ignored.
    mark(); kick_a(); wait_apply("sb");
    start_a = 1'b1; step(); start_a = 1'b0;
    wait_idle("sb", 2000);
    compare_run("sb", 40, 6);
    if (gs0 < gs_cyc.size()) check("sb done cycle", done_cyc - gs_cyc[gs0], 272);
    repeat (3) step();
    check("sb no restart", busy_a, 1'b0);

    // Reset in WAIT_CS of the third rotation, then a clean restart.
    mark(); kick_a();
    e = 0;
    while (gs_q.size() - gs0 < 3 && e < 500) begin step(); e++; end
    check("mr reached 3rd rotation", gs_q.size() - gs0, 3);
    repeat (5) step();
    reset = 1'b0; step();
    check_idle_zero("mid reset");
    dsnap = done_cnt; gsnap = gs_q.size();
    reset = 1'b1;
    repeat (50) step();
    check("mr no done", done_cnt - dsnap, 0);
    check("mr no issue", gs_q.size() - gsnap, 0);
    mark(); kick_a();
    check("mr restart pair", {gr_start_a, row_top_a, row_bot_a, col_a}, 7'b1_10_11_00);
    check("mr restart rot_cnt", rot_cnt_a, 8'd0);
    wait_idle("mr", 2000);
    compare_run("mr", 40, 6);

    // Randomised backpressure and operand values (b never zero here).
    for (int r = 0; r < 8; r++) begin
      int pct = $urandom_range(30, 90);
      mark(); kick_a();
      e = 0;
      while (busy_a && e < 5000) begin
        upd_ready_a = ($urandom_range(0, 99) < pct);
        b_elem = $urandom | 32'h1;
        step(); e++;
      end
      check($sformatf("rnd%0d run finished", r), busy_a, 1'b0);
      build_model(4, 1'b0);
      compare_run($sformatf("rnd%0d", r), 40, 6);
    end
    upd_ready_a = 1'b1;

    // Negative zero on the first ISSUE: skipped only when the feature is built in.
    b_elem = 32'h8000_0000;
    mark(); kick_a();
    step();
    b_elem = 32'h3f80_0000;
    wait_idle("skip", 2000);
    build_model(4, skip_on);
    compare_run("skip", 40, 6);

    // N=2 instance, one cycle at a time.
    b_elem = 32'h4000_0000;
    start_b = 1'b1; step(); start_b = 1'b0;
    check("n2 pair", {row_top_b, row_bot_b, col_b}, 3'b010);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("n2 cyc%0d ctl", i), {gr_start_b, cs_latch_b, upd_valid_b, done_b, busy_b},
            {bt[i].gs, bt[i].cs, bt[i].uv, bt[i].dn, bt[i].bsy});
      if (bt[i].ucol >= 0) check($sformatf("n2 cyc%0d upd_col", i), upd_col_b, bt[i].ucol);
      step();
    end
    check("n2 rot_cnt", rot_cnt_b, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/givens_qr_sched.md
Name: givens_qr_sched

Overview:
Sequences the pipelined Givens-rotation unit and the downstream row-update engine to perform an in-place N x N QR triangularisation. It walks sub-diagonal elements column by column, bottom-up within each column, and fires the rotation unit once per element. It waits the fixed rotation latency, then streams one row-update command per remaining column under ready/valid backpressure. It sits between the matrix-buffer address logic and the rotation/update datapath.

Parameters:
N, 4, matrix dimension (rows = columns); legal range 2..16
GR_LAT, 40, cycles from gr_start to valid cos/sin at the rotation unit output
IDX_W, $clog2(N), width of row/column indices
CNT_W, $clog2(GR_LAT+1), width of the latency counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  begin a decomposition; sampled only in IDLE
b_elem  in  32  IEEE-754 single, the current b element (R[row_bot][col]), valid during ISSUE
upd_ready  in  1  row-update engine accepts a command
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last rotation's final update is accepted
gr_start  out  1  one-cycle pulse: datapath presents a=R[row_top][col], b=R[row_bot][col] to the rotation unit
row_top  out  IDX_W  upper row of the active pair (row_bot-1)
row_bot  out  IDX_W  lower row of the active pair
col  out  IDX_W  column being annihilated
cs_latch  out  1  one-cycle pulse: capture cos/sin from the rotation unit
upd_valid  out  1  row-update command valid
upd_col  out  IDX_W  column the update applies to (col..N-1)
rot_cnt  out  8  rotations completed in this run

Behaviour:
- Reset (reset==0 at posedge): FSM goes to IDLE; all outputs become 0; counters clear. This applies mid-operation too, so any in-flight rotation is abandoned and no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT_CS, APPLY, NEXT, FIN.
- IDLE: when start==1, set col=0, row_bot=N-1, and go to ISSUE.
- ISSUE (1 cycle): assert gr_start, load the latency counter with GR_LAT-1, and go to WAIT_CS. Handling of zero b depends on SKIP_ZERO_EN (see Optional Feature).
- WAIT_CS: decrement the counter each cycle. At 0, assert cs_latch for exactly that cycle and go to APPLY. cs_latch therefore fires exactly GR_LAT cycles after gr_start.
- APPLY:
  - Hold upd_valid=1 with upd_col starting at col; the command stays stable while upd_ready==0.
  - On a handshake (upd_valid & upd_ready), upd_col increments.
  - The handshake with upd_col==N-1 drops upd_valid and goes to NEXT.
  - Each rotation issues N-col commands.
- NEXT (1 cycle): rot_cnt++.
  - If row_bot > col+1: row_bot--, go to ISSUE.
  - Else if col < N-2: col++, row_bot=N-1, go to ISSUE.
  - Else go to FIN.
- FIN (1 cycle): done=1, go to IDLE.
- rot_cnt holds its final value until the next start, where it clears.
- Only one rotation is ever in flight. Row dependencies between consecutive pairs make overlap illegal.
- Total rotations per run: N(N-1)/2.
- row_top is combinationally row_bot-1.
- start while busy is ignored.
- With upd_ready held 1, a rotation occupies 1 + GR_LAT + (N-col) + 1 cycles.

Optional Feature:
- Macro: GIVENS_SKIP_ZERO_EN.
- Defined: in ISSUE, if b_elem[30:0]==0 (+0 or -0), no gr_start, cs_latch or update is issued. The FSM goes straight to NEXT and rot_cnt still increments, because the element is already zero.
- Undefined: b_elem is ignored and every rotation is executed.

Decomposition:
- Shared package givens_pkg holds:
  - the state enum typedef
  - the FP32 width constant (32) and the sign/exponent/mantissa field positions used for the zero test
  - the default GR_LAT constant, shared with the rotation-unit instantiation
- One natural sub-module, givens_lat_cnt: a loadable down-counter with a terminal-count pulse, used for WAIT_CS.

Test Plan:
- Basic run: N=4, GR_LAT=40, upd_ready=1, start pulse.
  - Pairs (row_top,row_bot,col) in order: (2,3,0) (1,2,0) (0,1,0) (2,3,1) (1,2,1) (2,3,2).
  - 6 gr_start pulses; cs_latch exactly 40 cycles after each gr_start.
  - upd_col sequences 0-3, 0-3, 0-3, 1-3, 1-3, 2-3.
  - done once; rot_cnt=6.
- Backpressure: upd_ready=0 for 5 cycles during the first APPLY.
  - upd_valid held and upd_col=0 stable; no extra commands.
  - Total update handshakes = 4+4+4+3+3+2 = 20.
- Reset mid-run: drive reset=0 during WAIT_CS of the 3rd rotation.
  - Next cycle: busy=0, all outputs 0, no done.
  - A fresh start restarts at (2,3,0) with rot_cnt counting from 0.
- start while busy: pulse start in APPLY.
  - Sequence is unchanged and exactly one done pulse is produced.
- N=2: exactly 1 rotation (0,1,0), 2 update commands, then done.
- With GIVENS_SKIP_ZERO_EN: b_elem=32'h8000_0000 on the first ISSUE.
  - No gr_start for (2,3,0); rot_cnt still reaches 6; 5 gr_start pulses.
  - Without the macro, the same stimulus gives 6 gr_start pulses.
